// File: rtl/dvp_pattern_source.sv
// dvp_pattern_source
//   Synthesizable OV7670-style DVP transmitter. It generates pclk/href/vsync/data
//   exactly as the sensor does: RGB565 with the high byte first, carrying one of four
//   test patterns. It stands in for the camera during bring-up and regression.
//
//   Ports:
//     clk          system clock, the only clock
//     reset        synchronous, active-low
//     enable       run request, sampled at frame boundaries
//     pattern_sel  00 bars, 01 gradient, 10 solid, 11 checkerboard
//     solid_color  RGB565 value for the solid pattern
//     pclk         emitted pixel clock (clk/2)
//     href         line valid
//     vsync        frame sync, active high
//     data         byte bus
//     busy         high from frame start until frame end
//     frame_done   one-clk pulse at the end of each frame
//
//   Optional feature: define DVP_PATTERN_SCROLL_EN to scroll the checkerboard
//   by one pixel per frame. When it is undefined, the board is static.
module dvp_pattern_source #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        href,
  output logic        vsync,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW       = $clog2(LINE_LEN);
  localparam int unsigned V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int unsigned VW_RAW   = $clog2(V_MAX + 1);
  // At least 8 bits are needed because the gradient reads y[7:2].
  localparam int unsigned VW       = (VW_RAW > 8) ? VW_RAW : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  state_t          state;
  state_t          st_nxt;
  logic [HW-1:0]   h_cnt;
  logic [HW-1:0]   h_nxt;
  logic [VW-1:0]   v_cnt;
  logic [VW-1:0]   v_nxt;
  logic            frame_end;
  logic [1:0]      pat_q;
  logic [15:0]     solid_q;
  logic [7:0]      frame_cnt;
  logic [8:0]      x;
  logic [2:0]      bar_idx;
  logic            chk_x;
  logic [15:0]     bar_color;
  logic [15:0]     pix;
  logic [7:0]      pix_byte;

  // Position and state for the pclk period that starts at the next falling edge.
  // h_cnt counts pclk periods within a line. v_cnt counts lines within the current phase.
  always_comb begin
    st_nxt    = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    frame_end = 1'b0;
    if (h_cnt == HW'(LINE_LEN - 1)) begin
      h_nxt = '0;
      case (state)
        S_VSYNC: begin
          if (v_cnt == VW'(V_SYNC - 1)) begin
            st_nxt = S_VBACK;
            v_nxt  = '0;
          end else begin
            v_nxt = v_cnt + VW'(1);
          end
        end
        S_VBACK: begin
          if (v_cnt == VW'(V_BACK - 1)) begin
            st_nxt = S_ACTIVE;
            v_nxt  = '0;
          end else begin
            v_nxt = v_cnt + VW'(1);
          end
        end
        S_HBLANK: begin
          if (v_cnt == VW'(V_ACTIVE - 1)) begin
            st_nxt = S_VFRONT;
            v_nxt  = '0;
          end else begin
            st_nxt = S_ACTIVE;
            v_nxt  = v_cnt + VW'(1);
          end
        end
        S_VFRONT: begin
          if (v_cnt == VW'(V_FRONT - 1)) begin
            frame_end = 1'b1;
            st_nxt    = enable ? S_VSYNC : S_IDLE;
            v_nxt     = '0;
          end else begin
            v_nxt = v_cnt + VW'(1);
          end
        end
        default: ;
      endcase
    end else begin
      h_nxt = h_cnt + HW'(1);
      if (state == S_ACTIVE && h_cnt == HW'(2 * H_ACTIVE - 1)) begin
        st_nxt = S_HBLANK;
      end
    end
  end

  // Pixel x of the next byte slot. Each pixel uses two pclk periods.
  assign x       = 9'(h_nxt >> 1);
  assign bar_idx = 3'((32'(x) * 32'd8) / H_ACTIVE);

`ifdef DVP_PATTERN_SCROLL_EN
  // Bit 4 of (x + frame_cnt) mod 512. Only the low five bits of the sum matter.
  assign chk_x = x[4] ^ frame_cnt[4] ^
                 (({1'b0, x[3:0]} + {1'b0, frame_cnt[3:0]}) > 5'd15);
`else
  assign chk_x = x[4];
`endif

  // Pattern generator for the next byte slot
  always_comb begin
    bar_color = 16'h0000;
    pix       = 16'h0000;
    case (bar_idx)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
    case (pat_q)
      2'd0:    pix = bar_color;
      2'd1:    pix = {x[7:3], v_nxt[7:2], ~x[7:3]};
      2'd2:    pix = solid_q;
      default: pix = (chk_x ^ v_nxt[4]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  assign pix_byte = h_nxt[0] ? pix[7:0] : pix[15:8];

  // Sequencer. Everything except pclk changes only on the clk edge where pclk falls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pat_q      <= 2'd0;
      solid_q    <= 16'h0000;
      frame_cnt  <= 8'd0;
      pclk       <= 1'b0;
      href       <= 1'b0;
      vsync      <= 1'b0;
      data       <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        pclk  <= 1'b0;
        href  <= 1'b0;
        vsync <= 1'b0;
        data  <= 8'h00;
        busy  <= 1'b0;
        if (enable) begin
          state   <= S_VSYNC;
          h_cnt   <= '0;
          v_cnt   <= '0;
          vsync   <= 1'b1;
          busy    <= 1'b1;
          pat_q   <= pattern_sel;
          solid_q <= solid_color;
        end
      end else begin
        pclk <= ~pclk;
        if (pclk) begin
          state <= st_nxt;
          h_cnt <= h_nxt;
          v_cnt <= v_nxt;
          href  <= (st_nxt == S_ACTIVE);
          vsync <= (st_nxt == S_VSYNC);
          data  <= (st_nxt == S_ACTIVE) ? pix_byte : 8'h00;
          if (frame_end) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            busy       <= enable;
            if (enable) begin
              pat_q   <= pattern_sel;
              solid_q <= solid_color;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// tb_dvp_pattern_source
//   Self-checking bench for dvp_pattern_source. It uses a reduced geometry so that
//   many frames fit in a short run. Expected bytes are queued when the pattern inputs
//   are set, and they are popped as the DUT emits active bytes. Sync timing is checked
//   by a monitor that samples once per pclk high phase.
module tb_dvp_pattern_source;

  localparam int HA = 32;
  localparam int VA = 20;
  localparam int HB = 6;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int L  = 2 * HA + HB;
  localparam int FRAME_CLK = (VS + VB + VA + VF) * L * 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        pclk;
  logic        href;
  logic        vsync;
  logic [7:0]  data;
  logic        busy;
  logic        frame_done;

  dvp_pattern_source #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_FRONT  (VF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .pclk        (pclk),
    .href        (href),
    .vsync       (vsync),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] sb_q[$];

  int mon_line = -1;
  int mon_byte = 0;
  int vs_cnt = 0, gap_cnt = 0, hi_cnt = 0, lo_cnt = 0;
  int href_pulses = 0, fd_last = 0, idle_nz = 0;
  bit prev_h = 0, prev_vs = 0, gap_on = 0, lo_on = 0, fd_valid = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pixel(input logic [1:0] pat, input logic [15:0] solid,
                                              input int x, input int y, input int fc);
    logic [8:0] xv, yv, xc;
    xv = 9'(x);
    yv = 9'(y);
`ifdef DVP_PATTERN_SCROLL_EN
    xc = 9'((x + fc) % 512);
`else
    xc = 9'(x + 0 * fc);
`endif
    case (pat)
      2'd0: begin
        case ((x * 8) / HA)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1:    return {xv[7:3], yv[7:2], ~xv[7:3]};
      2'd2:    return solid;
      default: return (xc[4] ^ yv[4]) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] pat, input logic [15:0] solid, input int fc);
    logic [15:0] p;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        p = model_pixel(pat, solid, x, y, fc);
        sb_q.push_back(p[15:8]);
        sb_q.push_back(p[7:0]);
      end
    end
  endtask

  task automatic wait_frame_done();
    int n = 0;
    @(posedge clk); #1;
    while (frame_done !== 1'b1 && n < 2 * FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_pos(input int line, input int byte_idx);
    int n = 0;
    while (!(mon_line == line && mon_byte >= byte_idx) && n < 2 * FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("reached_line", 32'(mon_line), 32'(line));
  endtask

  // Monitor: one sample per pclk high phase, which is where a receiver latches data
  always @(negedge clk) begin
    if (!reset) begin
      mon_line = -1; mon_byte = 0; vs_cnt = 0; gap_cnt = 0; hi_cnt = 0; lo_cnt = 0;
      href_pulses = 0; idle_nz = 0;
      prev_h = 0; prev_vs = 0; gap_on = 0; lo_on = 0; fd_valid = 0;
    end else begin
      if (frame_done) begin
        check_eq("href_pulses_per_frame", 32'(href_pulses), 32'(VA));
        check_eq("blank_data_zero", 32'(idle_nz), 32'd0);
        if (fd_valid) check_eq("frame_period_clk", 32'(cyc - fd_last), 32'(FRAME_CLK));
        fd_last = cyc;
        fd_valid = busy;
        href_pulses = 0;
        idle_nz = 0;
      end
      if (pclk) begin
        if (vsync) begin
          vs_cnt++;
          mon_line = -1;
          lo_on = 0;
        end else if (prev_vs) begin
          check_eq("vsync_rises", 32'(vs_cnt), 32'(VS * L));
          vs_cnt = 0;
          gap_on = 1;
          gap_cnt = 0;
        end
        if (href) begin
          if (!prev_h) begin
            if (gap_on) check_eq("vback_gap", 32'(gap_cnt), 32'(VB * L));
            if (lo_on) check_eq("href_low_run", 32'(lo_cnt), 32'(HB));
            gap_on = 0;
            lo_on = 0;
            hi_cnt = 0;
            mon_line++;
            mon_byte = 0;
            href_pulses++;
          end
          hi_cnt++;
          check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) check_eq("pix_byte", 32'(data), 32'(sb_q.pop_front()));
          mon_byte++;
        end else begin
          if (prev_h) begin
            check_eq("href_high_run", 32'(hi_cnt), 32'(2 * HA));
            lo_on = 1;
            lo_cnt = 0;
          end
          if (lo_on) lo_cnt++;
          if (gap_on) gap_cnt++;
          if (data != 8'h00) idle_nz++;
        end
        prev_h = href;
        prev_vs = vsync;
      end
    end
  end

  initial begin
    int quiet;
    reset = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("rst_pclk", 32'(pclk), 32'd0);
    check_eq("rst_href", 32'(href), 32'd0);
    check_eq("rst_vsync", 32'(vsync), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);

    // Frame 0: color bars
    enable = 1'b1;
    push_frame(2'd0, 16'h0000, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_vsync", 32'(vsync), 32'd1);
    check_eq("start_pclk_low", 32'(pclk), 32'd0);
    @(posedge clk); #1;
    check_eq("first_pclk_high", 32'(pclk), 32'd1);

    // Frame 1: gradient
    pattern_sel = 2'd1;
    push_frame(2'd1, 16'h0000, 1);
    wait_frame_done();
    // Frame 2: solid F800
    pattern_sel = 2'd2;
    solid_color = 16'hF800;
    push_frame(2'd2, 16'hF800, 2);
    wait_frame_done();
    // A solid change in mid-frame 2 applies only from frame 3
    wait_pos(5, 0);
    solid_color = 16'h07E0;
    push_frame(2'd2, 16'h07E0, 3);
    wait_frame_done();
    // Frames 4 and 5: checkerboard
    pattern_sel = 2'd3;
    push_frame(2'd3, 16'h0000, 4);
    wait_frame_done();
    push_frame(2'd3, 16'h0000, 5);
    wait_frame_done();
    // Frame 6: bars; enable drops mid-frame
    pattern_sel = 2'd0;
    push_frame(2'd0, 16'h0000, 6);
    wait_frame_done();
    wait_pos(10, 0);
    enable = 1'b0;
    wait_frame_done();
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("drop_pclk", 32'(pclk), 32'd0);
    check_eq("drop_vsync", 32'(vsync), 32'd0);
    quiet = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (pclk || vsync || busy || href || frame_done) quiet++;
    end
    check_eq("idle_quiet", 32'(quiet), 32'd0);
    check_eq("sb_drained_f6", 32'(sb_q.size()), 32'd0);

    // Reset pulse in mid-line of line 10
    pattern_sel = 2'd1;
    enable = 1'b1;
    push_frame(2'd1, 16'h0000, 7);
    wait_pos(10, 40);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_outputs", 32'({pclk, href, vsync, data, busy, frame_done}), 32'd0);
    reset = 1'b1;
    pattern_sel = 2'd3;
    sb_q.delete();
    push_frame(2'd3, 16'h0000, 0);
    @(posedge clk); #1;
    check_eq("restart_vsync", 32'(vsync), 32'd1);
    enable = 1'b0;
    wait_frame_done();
    check_eq("final_busy", 32'(busy), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
